// File: rtl/cache_pkg.sv
// Shared constants, op encoding and FSM state type for the cache backing-memory responder.
package cache_pkg;

    localparam int          CACHE_ADDR_W = 6;
    localparam int          CACHE_DATA_W = 32;
    localparam logic [31:0] INIT_PAT     = 32'hDEADBEEF;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/cache_mem_store.sv
// Word storage with per-word written flags; never-written words read back as an
// address-derived pattern so refills are distinguishable before any writeback.
module cache_mem_store #(
    parameter int                ADDR_W   = cache_pkg::CACHE_ADDR_W,
    parameter int                DATA_W   = cache_pkg::CACHE_DATA_W,
    parameter int                DEPTH    = 2 ** ADDR_W,
    parameter logic [DATA_W-1:0] INIT_PAT = cache_pkg::INIT_PAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  written_q;
    logic [DEPTH-1:0]  written_d;

    always_comb begin
        written_d = written_q;
        if (wr_en) begin
            written_d[wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written_q <= '0;
        end else begin
            written_q <= written_d;
        end
    end

    // Data array is deliberately not reset; the written flags gate its use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = written_q[rd_addr] ? mem_q[rd_addr]
                                        : (INIT_PAT ^ DATA_W'(rd_addr));

endmodule

// File: rtl/cache_backing_mem_responder.sv
// Main-memory-side responder for the cache refill/writeback port: one request at a
// time, response after a programmable latency, saturating read/write counters.
module cache_backing_mem_responder #(
    parameter int                ADDR_W   = cache_pkg::CACHE_ADDR_W,
    parameter int                DATA_W   = cache_pkg::CACHE_DATA_W,
    parameter int                DEPTH    = 64,
    parameter int                LATENCY  = 4,
    parameter logic [DATA_W-1:0] INIT_PAT = cache_pkg::INIT_PAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_rw,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic [7:0]        rd_count,
    output logic [7:0]        wr_count
);

    import cache_pkg::*;

    state_e            state_q, state_d;
    logic [3:0]        lat_cnt_q, lat_cnt_d;
    logic              resp_rw_q, resp_rw_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [7:0]        rd_count_q, rd_count_d;
    logic [7:0]        wr_count_q, wr_count_d;
    logic              wr_en;
    logic [DATA_W-1:0] store_rd_data;

    assign wr_en = (state_q == IDLE) && req_valid && (req_rw == OP_WRITE);

    cache_mem_store #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .INIT_PAT (INIT_PAT)
    ) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (req_addr),
        .wr_data (req_wdata),
        .rd_addr (req_addr),
        .rd_data (store_rd_data)
    );

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        resp_rw_d    = resp_rw_q;
        resp_rdata_d = resp_rdata_q;
        rd_count_d   = rd_count_q;
        wr_count_d   = wr_count_q;
        req_ready    = (state_q == IDLE);
        resp_valid   = (state_q == RESP);
        busy         = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    // Always pass through WAIT (even for LATENCY==1) so RESP starts
                    // exactly LATENCY edges after accept; the counter expires at zero.
                    state_d      = WAIT;
                    lat_cnt_d    = 4'(LATENCY - 1);
                    resp_rw_d    = req_rw;
                    resp_rdata_d = (req_rw == OP_WRITE) ? req_wdata : store_rd_data;
                    if (req_rw == OP_WRITE) begin
                        if (wr_count_q != 8'hFF) wr_count_d = wr_count_q + 8'd1;
                    end else begin
                        if (rd_count_q != 8'hFF) rd_count_d = rd_count_q + 8'd1;
                    end
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            resp_rw_q    <= 1'b0;
            resp_rdata_q <= '0;
            rd_count_q   <= '0;
            wr_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            resp_rw_q    <= resp_rw_d;
            resp_rdata_q <= resp_rdata_d;
            rd_count_q   <= rd_count_d;
            wr_count_q   <= wr_count_d;
        end
    end

    assign resp_rw    = resp_rw_q;
    assign resp_rdata = resp_rdata_q;
    assign rd_count   = rd_count_q;
    assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_cache_backing_mem_responder.sv
// Bench for cache_backing_mem_responder: directed table, reset/saturation sequences and
// random traffic compared against an array-based memory model.
module tb_cache_backing_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_valid1 = 1'b0;
    logic        req_rw = 1'b0;
    logic [5:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b0;

    logic        req_ready, resp_valid, resp_rw, busy;
    logic [31:0] resp_rdata;
    logic [7:0]  rd_count, wr_count;

    logic        req_ready1, resp_valid1, resp_rw1, busy1;
    logic [31:0] resp_rdata1;
    logic [7:0]  rd_count1, wr_count1;

    always #5 clk = ~clk;

    cache_backing_mem_responder #(.LATENCY(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rw(resp_rw),
        .resp_rdata(resp_rdata), .busy(busy), .rd_count(rd_count), .wr_count(wr_count)
    );

    cache_backing_mem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid1), .resp_ready(resp_ready), .resp_rw(resp_rw1),
        .resp_rdata(resp_rdata1), .busy(busy1), .rd_count(rd_count1), .wr_count(wr_count1)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain memory image, written flags and access tallies.
    logic [31:0] m_mem [64];
    bit          m_wr  [64];
    int          m_rd = 0;
    int          m_wrc = 0;

    function automatic logic [31:0] m_read(input logic [5:0] a);
        logic [31:0] pat;
        pat = 32'hDEADBEEF ^ {26'd0, a};
        return m_wr[a] ? m_mem[a] : pat;
    endfunction

    function automatic logic [7:0] sat8(input int c);
        logic [31:0] v;
        v = c;
        return (c > 255) ? 8'hFF : v[7:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_wr[i] = 1'b0;
        m_rd  = 0;
        m_wrc = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One complete transaction on the LATENCY=4 instance; resp_ready held low for
    // 'hold' cycles of RESP, with a stray request pulse that must be ignored.
    task automatic transact(input logic rw, input logic [5:0] a, input logic [31:0] wd,
                            input int hold, output logic [31:0] got);
        logic [31:0] exp;
        int          lat;
        exp = rw ? wd : m_read(a);
        @(negedge clk);
        req_valid  = 1'b1;
        req_rw     = rw;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = (hold == 0);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        if (rw) begin
            m_mem[a] = wd;
            m_wr[a]  = 1'b1;
            m_wrc++;
        end else begin
            m_rd++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_rw    = 1'($urandom);
        req_addr  = 6'($urandom);
        req_wdata = $urandom;
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, 32'd4);
        chk("resp_rw", {31'd0, resp_rw}, {31'd0, rw});
        chk("resp_rdata", resp_rdata, exp);
        chk("busy_resp", {31'd0, busy}, 32'd1);
        chk("req_ready_resp", {31'd0, req_ready}, 32'd0);
        got = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            req_valid = (i == hold / 2);
            req_rw    = 1'b1;
            req_addr  = a ^ 6'd1;
            req_wdata = ~wd;
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_rdata", resp_rdata, exp);
            chk("hold_rw", {31'd0, resp_rw}, {31'd0, rw});
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("idle_after", {29'd0, busy, resp_valid, req_ready}, 32'd1);
        chk("rd_count", {24'd0, rd_count}, {24'd0, sat8(m_rd)});
        chk("wr_count", {24'd0, wr_count}, {24'd0, sat8(m_wrc)});
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, "_flags"}, {28'd0, req_ready, resp_valid, resp_rw, busy}, 32'h8);
        chk({nm, "_rdata"}, resp_rdata, 32'd0);
        chk({nm, "_counts"}, {16'd0, rd_count, wr_count}, 32'd0);
    endtask

    typedef struct {
        logic        rw;
        logic [5:0]  addr;
        logic [31:0] wdata;
        int          hold;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [31:0] got;
        int          lat;

        tbl[0] = '{1'b0, 6'h05, 32'h0,        0,  32'hDEADBEEA};
        tbl[1] = '{1'b1, 6'h0A, 32'hCAFEBABE, 0,  32'hCAFEBABE};
        tbl[2] = '{1'b0, 6'h0A, 32'h0,        10, 32'hCAFEBABE};
        tbl[3] = '{1'b0, 6'h0B, 32'h0,        0,  32'hDEADBEE4};
        tbl[4] = '{1'b1, 6'h00, 32'h12345678, 2,  32'h12345678};
        tbl[5] = '{1'b0, 6'h00, 32'h0,        0,  32'h12345678};
        tbl[6] = '{1'b0, 6'h3F, 32'h0,        1,  32'hDEADBED0};

        model_reset();
        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_state("post_reset");

        for (int i = 0; i < 7; i++) begin
            transact(tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].hold, got);
            chk($sformatf("tbl%0d_data", i), got, tbl[i].exp_data);
        end
        chk("tbl_counts", {16'd0, rd_count, wr_count}, {16'd0, 8'd5, 8'd2});

        // Write 3F, then reset during WAIT of a following read.
        transact(1'b1, 6'h3F, 32'h11223344, 0, got);
        @(negedge clk);
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_addr  = 6'h3F;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("busy_wait", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_wait");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        transact(1'b0, 6'h3F, 32'h0, 0, got);
        chk("read_after_rst", got, 32'hDEADBED0);

        // Reset while a response is being held.
        @(negedge clk);
        req_valid  = 1'b1;
        req_rw     = 1'b0;
        req_addr   = 6'h01;
        resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("held_valid", {31'd0, resp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_resp");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 150; i++) begin
            transact(1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), $urandom,
                     $urandom_range(0, 3), got);
        end

        for (int i = 0; i < 300; i++) begin
            transact(1'b0, 6'($urandom), 32'h0, 0, got);
        end
        chk("rd_sat", {24'd0, rd_count}, 32'hFF);

        // LATENCY=1 instance: response on the edge after accept.
        @(negedge clk);
        req_valid1 = 1'b1;
        req_rw     = 1'b0;
        req_addr   = 6'h00;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid1 = 1'b0;
        lat = 0;
        while (!resp_valid1 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("lat1_latency", lat, 32'd1);
        chk("lat1_rdata", resp_rdata1, 32'hDEADBEEF);
        chk("lat1_count", {24'd0, rd_count1}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("lat1_idle", {31'd0, resp_valid1}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
